tte_flow_lookup: RTL and testbench

- Initiator side of the TTE flow-table search interface.
- Accepts one parsed frame header (dmac, smac) at a time from the ingress parser and computes the 12-bit bucket hash.
- Drives the se_req/se_ack/se_nak handshake toward the flow-table bucket, then returns hit/miss plus a 16-bit portmap to the forwarding stage.
- Keeps hit, miss and timeout statistics.

---
 rtl/tte_pkg.sv | 47 ++++
 rtl/tte_sat_cnt16.sv | 18 +
 rtl/tte_flow_lookup.sv | 117 +++++++++++
 tb/tb_tte_flow_lookup.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tte_pkg.sv
// Shared definitions for the TTE flow-table search path: widths, entry layout,
// lookup FSM encoding and the bucket hash shared with the table-update writer.
package tte_pkg;

  localparam int TTE_HASH_W = 12;
  localparam int TTE_PORT_W = 16;
  localparam int MAC_W      = 48;

  // Flow-table entry layout; bits 118:112 are reserved.
  localparam int ENT_PORTMAP_LSB = 0;
  localparam int ENT_DMAC_LSB    = 16;
  localparam int ENT_SMAC_LSB    = 64;
  localparam int ENT_VALID_BIT   = 119;
  localparam int ENT_W           = 120;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HASH,
    ST_WAIT,
    ST_RESP,
    ST_GAP
  } tte_state_t;

  // XOR-fold of the eight 12-bit slices of {dmac, smac}.
  function automatic logic [TTE_HASH_W-1:0] tte_hash12(input logic [MAC_W-1:0] dmac,
                                                      input logic [MAC_W-1:0] smac);
    logic [2*MAC_W-1:0]    key;
    logic [TTE_HASH_W-1:0] h;
    key = {dmac, smac};
    h   = '0;
    for (int k = 0; k < 8; k++) h ^= key[TTE_HASH_W*k +: TTE_HASH_W];
    return h;
  endfunction

  function automatic logic [ENT_W-1:0] tte_entry(input logic [MAC_W-1:0]      dmac,
                                                 input logic [MAC_W-1:0]      smac,
                                                 input logic [TTE_PORT_W-1:0] portmap);
    logic [ENT_W-1:0] e;
    e = '0;
    e[ENT_PORTMAP_LSB +: TTE_PORT_W] = portmap;
    e[ENT_DMAC_LSB +: MAC_W]         = dmac;
    e[ENT_SMAC_LSB +: MAC_W]         = smac;
    e[ENT_VALID_BIT]                 = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/tte_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module tte_sat_cnt16 (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  output logic [15:0] count
);

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (en && count != 16'hFFFF) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/tte_flow_lookup.sv
// Flow-table search initiator: hashes one header, runs the se_req/se_ack/se_nak
// handshake with a bounded wait, returns hit/miss/timeout and keeps statistics.
module tte_flow_lookup
  import tte_pkg::*;
#(
  parameter int                    TIMEOUT      = 8192,
  parameter logic [TTE_PORT_W-1:0] MISS_PORTMAP = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  hdr_valid,
  output logic                  hdr_ready,
  input  logic [MAC_W-1:0]      hdr_dmac,
  input  logic [MAC_W-1:0]      hdr_smac,
  output logic                  se_req,
  output logic [MAC_W-1:0]      se_dmac,
  output logic [MAC_W-1:0]      se_smac,
  output logic [TTE_HASH_W-1:0] se_hash,
  input  logic                  se_ack,
  input  logic                  se_nak,
  input  logic [TTE_PORT_W-1:0] se_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_hit,
  output logic                  res_timeout,
  output logic [TTE_PORT_W-1:0] res_portmap,
  output logic [15:0]           stat_hit,
  output logic [15:0]           stat_miss,
  output logic [15:0]           stat_tmo
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  tte_state_t       state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic             in_wait, hit_ev, miss_ev, tmo_ev;

  // Ack beats nak, and any answer beats a timeout landing on the same cycle.
  assign in_wait = (state == ST_WAIT);
  assign hit_ev  = in_wait & se_ack;
  assign miss_ev = in_wait & se_nak & ~se_ack;
  assign tmo_ev  = in_wait & ~se_ack & ~se_nak & (timer == TMR_W'(TIMEOUT - 1));

  assign hdr_ready = (state == ST_IDLE);
  assign res_valid = (state == ST_RESP);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (hdr_valid) state_nxt = ST_HASH;
      ST_HASH: state_nxt = ST_WAIT;
      ST_WAIT: if (hit_ev || miss_ev || tmo_ev) state_nxt = ST_RESP;
      ST_RESP: if (res_ready) state_nxt = ST_GAP;
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      se_req      <= 1'b0;
      se_dmac     <= '0;
      se_smac     <= '0;
      se_hash     <= '0;
      timer       <= '0;
      res_hit     <= 1'b0;
      res_timeout <= 1'b0;
      res_portmap <= MISS_PORTMAP;
    end else begin
      unique case (state)
        ST_IDLE: if (hdr_valid) begin
          se_dmac <= hdr_dmac;
          se_smac <= hdr_smac;
        end
        ST_HASH: begin
          se_hash <= tte_hash12(se_dmac, se_smac);
          se_req  <= 1'b1;
          timer   <= '0;
        end
        ST_WAIT: begin
          if (hit_ev) begin
            se_req      <= 1'b0;
            res_hit     <= 1'b1;
            res_portmap <= se_result;
          end else if (miss_ev) begin
            se_req      <= 1'b0;
            res_hit     <= 1'b0;
            res_portmap <= MISS_PORTMAP;
          end else if (tmo_ev) begin
            se_req      <= 1'b0;
            res_hit     <= 1'b0;
            res_timeout <= 1'b1;
            res_portmap <= MISS_PORTMAP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_RESP: if (res_ready) begin
          res_hit     <= 1'b0;
          res_timeout <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  tte_sat_cnt16 u_cnt_hit  (.clk(clk), .rstn(rstn), .en(hit_ev),  .count(stat_hit));
  tte_sat_cnt16 u_cnt_miss (.clk(clk), .rstn(rstn), .en(miss_ev), .count(stat_miss));
  tte_sat_cnt16 u_cnt_tmo  (.clk(clk), .rstn(rstn), .en(tmo_ev),  .count(stat_tmo));

endmodule

// File: tb/tb_tte_flow_lookup.sv
// Scoreboard bench for tte_flow_lookup: directed lookups push expected results,
// a monitor pops and compares on every res_valid/res_ready handshake.
module tb_tte_flow_lookup;

  localparam int TIMEOUT = 8192;

  typedef struct {
    logic        hit;
    logic        tmo;
    logic [15:0] pm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hdr_valid, hdr_ready;
  logic [47:0] hdr_dmac, hdr_smac;
  logic        se_req;
  logic [47:0] se_dmac, se_smac;
  logic [11:0] se_hash;
  logic        se_ack, se_nak;
  logic [15:0] se_result;
  logic        res_valid, res_ready, res_hit, res_timeout;
  logic [15:0] res_portmap, stat_hit, stat_miss, stat_tmo;

  int   checks = 0;
  int   errors = 0;
  int   n_push = 0;
  int   n_res  = 0;
  exp_t exp_q[$];

  tte_flow_lookup #(.TIMEOUT(TIMEOUT), .MISS_PORTMAP(16'h0000)) dut (
    .clk(clk), .rstn(rstn),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_dmac(hdr_dmac), .hdr_smac(hdr_smac),
    .se_req(se_req), .se_dmac(se_dmac), .se_smac(se_smac), .se_hash(se_hash),
    .se_ack(se_ack), .se_nak(se_nak), .se_result(se_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .res_timeout(res_timeout), .res_portmap(res_portmap),
    .stat_hit(stat_hit), .stat_miss(stat_miss), .stat_tmo(stat_tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference hash written as a 48-bit fold of dmac^smac.
  function automatic logic [11:0] model_hash(input logic [47:0] d, input logic [47:0] s);
    logic [47:0] x;
    x = d ^ s;
    return x[11:0] ^ x[23:12] ^ x[35:24] ^ x[47:36];
  endfunction

  task automatic expect_res(input logic hit, input logic tmo, input logic [15:0] pm);
    exp_t e;
    e.hit = hit; e.tmo = tmo; e.pm = pm;
    exp_q.push_back(e);
    n_push++;
  endtask

  task automatic start_hdr(input logic [47:0] d, input logic [47:0] s);
    @(negedge clk);
    hdr_valid = 1'b1;
    hdr_dmac  = d;
    hdr_smac  = s;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (!hdr_ready && n < 100) begin @(negedge clk); n++; end
    check("hdr_accept", hdr_ready, 1);
    @(negedge clk);
    hdr_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!se_req && n < 20) begin @(negedge clk); n++; end
    check("se_req_rise", se_req, 1);
  endtask

  // kind: 0 = ack, 1 = nak, 2 = ack and nak together
  task automatic respond(input int kind, input logic [15:0] r);
    repeat (4) @(negedge clk);
    check("se_req_held", se_req, 1);
    se_ack    = (kind != 1);
    se_nak    = (kind != 0);
    se_result = r;
    @(negedge clk);
    se_ack    = 1'b0;
    se_nak    = 1'b0;
    se_result = '0;
    check("se_req_drop", se_req, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!hdr_ready && n < 100) begin @(negedge clk); n++; end
    check("return_idle", hdr_ready, 1);
  endtask

  task automatic check_stats(input string tag, input logic [15:0] h, input logic [15:0] m,
                             input logic [15:0] t);
    check({tag, "_stat_hit"},  stat_hit,  h);
    check({tag, "_stat_miss"}, stat_miss, m);
    check({tag, "_stat_tmo"},  stat_tmo,  t);
  endtask

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rstn && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got portmap %0h with none expected", res_portmap);
      end else begin
        e = exp_q.pop_front();
        check("res_hit",     res_hit,     e.hit);
        check("res_timeout", res_timeout, e.tmo);
        check("res_portmap", res_portmap, e.pm);
        n_res++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stable, g1, g2;
    int   cnt;
    rstn = 1'b0; hdr_valid = 1'b0; hdr_dmac = '0; hdr_smac = '0;
    se_ack = 1'b0; se_nak = 1'b0; se_result = '0; res_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_hdr_ready", hdr_ready, 1);
    check("rst_se_req", se_req, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_portmap", res_portmap, 16'h0000);
    check("rst_se_hash", se_hash, 0);
    check_stats("rst", 0, 0, 0);
    rstn = 1'b1;

    // 1: hit
    expect_res(1'b1, 1'b0, 16'h0004);
    start_hdr(48'h000000000001, 48'h0);
    wait_accept();
    wait_req();
    check("t1_se_hash", se_hash, 12'h001);
    check("t1_se_dmac", se_dmac, 48'h000000000001);
    respond(0, 16'h0004);
    wait_idle();
    check_stats("t1", 1, 0, 0);

    // 2: miss
    expect_res(1'b0, 1'b0, 16'h0000);
    start_hdr(48'h60beb403060e, 48'h60beb403644d);
    wait_accept();
    wait_req();
    check("t2_se_hash", se_hash, 12'h245);
    check("t2_se_hash_model", se_hash, model_hash(48'h60beb403060e, 48'h60beb403644d));
    check("t2_se_smac", se_smac, 48'h60beb403644d);
    respond(1, 16'h1234);
    wait_idle();
    check_stats("t2", 1, 1, 0);

    // 3: no response, then a late ack
    expect_res(1'b0, 1'b1, 16'h0000);
    start_hdr(48'h123456789abc, 48'h0f0f0f0f0f0f);
    wait_accept();
    wait_req();
    cnt = 0;
    while (se_req && cnt < TIMEOUT + 100) begin cnt++; @(negedge clk); end
    check("t3_req_hold_cycles", cnt, TIMEOUT);
    wait_idle();
    repeat (5) @(negedge clk);
    se_ack = 1'b1; se_result = 16'hbeef;
    @(negedge clk);
    se_ack = 1'b0; se_result = '0;
    repeat (3) @(negedge clk);
    check("t3_late_no_valid", res_valid, 0);
    check_stats("t3", 1, 1, 1);

    // 4: backpressure
    res_ready = 1'b0;
    expect_res(1'b1, 1'b0, 16'h0010);
    start_hdr(48'h00000000aaaa, 48'h0);
    wait_accept();
    wait_req();
    respond(0, 16'h0010);
    start_hdr(48'h000000000002, 48'h0);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (hdr_ready !== 1'b0 || res_valid !== 1'b1 || res_hit !== 1'b1 ||
          res_timeout !== 1'b0 || res_portmap !== 16'h0010) stable = 1'b0;
    end
    check("t4_hold_stable", stable, 1);
    res_ready = 1'b1;
    @(negedge clk); g1 = hdr_ready;
    @(negedge clk); g2 = hdr_ready;
    check("t4_gap_not_ready", g1, 0);
    check("t4_ready_after_gap", g2, 1);
    expect_res(1'b0, 1'b0, 16'h0000);
    wait_accept();
    wait_req();
    check("t4_se_dmac_next", se_dmac, 48'h000000000002);
    respond(1, 16'h0000);
    wait_idle();
    check_stats("t4", 2, 2, 1);

    // 5: ack+nak together, hit counter saturation
    @(negedge clk);
    force dut.u_cnt_hit.count = 16'hfffe;
    #1;
    release dut.u_cnt_hit.count;
    @(negedge clk);
    check("t5_preload", stat_hit, 16'hfffe);
    expect_res(1'b1, 1'b0, 16'h0002);
    start_hdr(48'h0000000000f0, 48'h00000000000f);
    wait_accept();
    wait_req();
    respond(2, 16'h0002);
    wait_idle();
    check_stats("t5a", 16'hffff, 2, 1);
    expect_res(1'b1, 1'b0, 16'h0008);
    start_hdr(48'h0000000000f1, 48'h0);
    wait_accept();
    wait_req();
    respond(0, 16'h0008);
    wait_idle();
    check_stats("t5b", 16'hffff, 2, 1);

    // 6: reset in the middle of WAIT
    start_hdr(48'h0a0b0c0d0e0f, 48'h010203040506);
    wait_accept();
    wait_req();
    #2 rstn = 1'b0;
    #1;
    check("t6_se_req_async", se_req, 0);
    check("t6_hdr_ready", hdr_ready, 1);
    check("t6_res_valid", res_valid, 0);
    check_stats("t6", 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_result", res_valid, 0);
    expect_res(1'b1, 1'b0, 16'h0100);
    start_hdr(48'h000000000003, 48'h0);
    wait_accept();
    wait_req();
    respond(0, 16'h0100);
    wait_idle();
    check_stats("t6_recover", 1, 0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("result_count", n_res, n_push);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
